// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: sync, blanking and pixel coordinates.
// Counters step on pix_en; decode is registered from the next count.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic        h_sinc,
  output logic        v_sinc,
  output logic        video_on,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);
  localparam logic [10:0] HS_LO = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_HI = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_LO = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_HI = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        hs_q, vs_q, vo_q, ls_q, fs_q;
  logic        x_wrap;

  always_comb begin
    x_wrap = (x_q == H_MAX);
    x_d    = x_wrap ? 11'd0 : x_q + 11'd1;
    y_d    = y_q;
    if (x_wrap) begin
      y_d = (y_q == V_MAX) ? 11'd0 : y_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= H_MAX;
      y_q  <= V_MAX;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      vo_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (pix_en) begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= ((x_d >= HS_LO) && (x_d < HS_HI)) ? SYNC_POL : ~SYNC_POL;
      vs_q <= ((y_d >= VS_LO) && (y_d < VS_HI)) ? SYNC_POL : ~SYNC_POL;
      vo_q <= (x_d < H_VIS) && (y_d < V_VIS);
      ls_q <= (x_d == 11'd0);
      fs_q <= (x_d == 11'd0) && (y_d == 11'd0);
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end
  end

  assign pos_x       = x_q;
  assign pos_y       = y_q;
  assign h_sinc      = hs_q;
  assign v_sinc      = vs_q;
  assign video_on    = vo_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced raster so whole
// frames, wraps and mid-frame async resets fit in a short run.
module tb_vga_sync_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int NCYC = 4000;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        vo;
    logic        ls;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic        h_sinc, v_sinc, video_on;
  logic [10:0] pos_x, pos_y;
  logic        line_start, frame_start;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  bit done = 0;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_en(pix_en),
    .h_sinc(h_sinc),
    .v_sinc(v_sinc),
    .video_on(video_on),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Position is fully determined by enabled ticks since reset.
  function automatic exp_t model(int n, bit tick);
    exp_t e;
    int t;
    if (n == 0) begin
      e.x = 11'(HT - 1);
      e.y = 11'(VT - 1);
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.vo = 1'b0;
      e.ls = 1'b0;
      e.fs = 1'b0;
    end else begin
      t = (n - 1) % (HT * VT);
      e.x = 11'(t % HT);
      e.y = 11'(t / HT);
      e.hs = !((t % HT) >= HV + HF && (t % HT) < HV + HF + HS);
      e.vs = !((t / HT) >= VV + VF && (t / HT) < VV + VF + VS);
      e.vo = ((t % HT) < HV) && ((t / HT) < VV);
      e.ls = tick && (t % HT == 0);
      e.fs = tick && (t == 0);
    end
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d",
               name, $time, act, req);
    end
  endtask

  initial begin
    int n;
    bit tick;
    n = 0;
    rst_n = 1'b0;
    pix_en = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      tick = rst_n && pix_en;
      if (tick) n++;
      if (cyc < 3) begin
        rst_n = 1'b0;
      end else if (cyc > 400 && $urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        n = 0;
        tick = 0;
      end else begin
        rst_n = 1'b1;
      end
      if (cyc < 400) pix_en = 1'b1;
      else if (cyc < 1200) pix_en = cyc[0];
      else pix_en = 1'($urandom_range(0, 1));
      #1;
      q.push_back(model(n, tick));
    end
    @(negedge clk);
    #1;
    done = 1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done && q.size() > 0) begin
        e = q.pop_front();
        chk("pos_x", int'(pos_x), int'(e.x));
        chk("pos_y", int'(pos_y), int'(e.y));
        chk("h_sinc", int'(h_sinc), int'(e.hs));
        chk("v_sinc", int'(v_sinc), int'(e.vs));
        chk("video_on", int'(video_on), int'(e.vo));
        chk("line_start", int'(line_start), int'(e.ls));
        chk("frame_start", int'(frame_start), int'(e.fs));
      end
    end
  end

endmodule
